// File: rtl/ber_prbs_checker.sv
// Self-synchronising PRBS7 (x^7+x^6+1) checker with saturating bit/error accumulators and a
// periodic snapshot strobe feeding the BER display stage.
module ber_prbs_checker #(
  parameter int unsigned REPORT_PERIOD = 50_000_000,
  parameter int unsigned SYNC_LEN      = 16,
  parameter int unsigned LOL_WIN       = 64,
  parameter int unsigned LOL_THRESH    = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        DIN,
  input  logic        DIN_VALID,
  input  logic        CLEAR,
  output logic        START,
  output logic [57:0] RECV_CNT,
  output logic [63:0] ERR_CNT,
  output logic        LOCKED
);

  localparam logic [8:0]  LP_SYNC   = 9'(SYNC_LEN);
  localparam logic [8:0]  LP_WIN    = 9'(LOL_WIN);
  localparam logic [8:0]  LP_THRESH = 9'(LOL_THRESH);
  localparam logic [31:0] LP_LAST   = 32'(REPORT_PERIOD - 1);

  typedef enum logic [1:0] {StHunt, StVerify, StLock} state_e;

  state_e      r_state,     w_state_nxt;
  logic [6:0]  r_sr,        w_sr_nxt;
  logic [2:0]  r_fill,      w_fill_nxt;
  logic [7:0]  r_match,     w_match_nxt;
  logic [7:0]  r_win_bits,  w_win_bits_nxt;
  logic [7:0]  r_win_errs,  w_win_errs_nxt;
  logic [57:0] r_recv_acc,  w_recv_acc_nxt;
  logic [63:0] r_err_acc,   w_err_acc_nxt;
  logic [31:0] r_period,    w_period_nxt;
  logic        r_start,     w_start_nxt;
  logic [57:0] r_recv_snap, w_recv_snap_nxt;
  logic [63:0] r_err_snap,  w_err_snap_nxt;

  logic       w_pred, w_bit_err, w_last, w_recv_inc, w_err_inc;
  logic [8:0] w_match_inc, w_win_bits_inc, w_win_errs_inc;

  assign w_pred         = r_sr[6] ^ r_sr[5];
  assign w_bit_err      = DIN ^ w_pred;
  assign w_last         = (r_period == LP_LAST);
  assign w_match_inc    = {1'b0, r_match} + 9'd1;
  assign w_win_bits_inc = {1'b0, r_win_bits} + 9'd1;
  assign w_win_errs_inc = {1'b0, r_win_errs} + {8'd0, w_bit_err};

  always_comb begin
    w_state_nxt    = r_state;
    w_sr_nxt       = r_sr;
    w_fill_nxt     = r_fill;
    w_match_nxt    = r_match;
    w_win_bits_nxt = r_win_bits;
    w_win_errs_nxt = r_win_errs;
    w_recv_inc     = 1'b0;
    w_err_inc      = 1'b0;
    if (DIN_VALID) begin
      unique case (r_state)
        StHunt: begin
          w_sr_nxt = {r_sr[5:0], DIN};
          if (r_fill == 3'd6) begin
            w_fill_nxt  = '0;
            w_match_nxt = '0;
            w_state_nxt = StVerify;
          end else begin
            w_fill_nxt = r_fill + 3'd1;
          end
        end
        StVerify: begin
          if (!w_bit_err) begin
            w_sr_nxt    = {r_sr[5:0], DIN};
            w_match_nxt = w_match_inc[7:0];
            if (w_match_inc == LP_SYNC) begin
              w_state_nxt    = StLock;
              w_win_bits_nxt = '0;
              w_win_errs_nxt = '0;
            end
          end else begin
            // sr keeps its contents; the next 7 hunt bits overwrite it anyway
            w_state_nxt = StHunt;
            w_fill_nxt  = '0;
          end
        end
        StLock: begin
          w_sr_nxt   = {r_sr[5:0], w_pred};
          w_recv_inc = 1'b1;
          w_err_inc  = w_bit_err;
          if (w_win_bits_inc == LP_WIN) begin
            w_win_bits_nxt = '0;
            w_win_errs_nxt = '0;
            if (w_win_errs_inc >= LP_THRESH) begin
              w_state_nxt = StHunt;
              w_fill_nxt  = '0;
            end
          end else begin
            w_win_bits_nxt = w_win_bits_inc[7:0];
            w_win_errs_nxt = w_win_errs_inc[7:0];
          end
        end
        default: w_state_nxt = StHunt;
      endcase
    end
  end

  always_comb begin
    w_recv_acc_nxt = r_recv_acc;
    w_err_acc_nxt  = r_err_acc;
    if (w_recv_inc && (r_recv_acc != '1)) w_recv_acc_nxt = r_recv_acc + 58'd1;
    if (w_err_inc && (r_err_acc != '1))   w_err_acc_nxt  = r_err_acc + 64'd1;
    w_period_nxt    = w_last ? '0 : r_period + 32'd1;
    w_start_nxt     = w_last;
    w_recv_snap_nxt = w_last ? w_recv_acc_nxt : r_recv_snap;
    w_err_snap_nxt  = w_last ? w_err_acc_nxt : r_err_snap;
    if (CLEAR) begin
      w_recv_acc_nxt  = '0;
      w_err_acc_nxt   = '0;
      w_period_nxt    = '0;
      w_start_nxt     = 1'b0;
      w_recv_snap_nxt = r_recv_snap;
      w_err_snap_nxt  = r_err_snap;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= StHunt;
      r_sr        <= '0;
      r_fill      <= '0;
      r_match     <= '0;
      r_win_bits  <= '0;
      r_win_errs  <= '0;
      r_recv_acc  <= '0;
      r_err_acc   <= '0;
      r_period    <= '0;
      r_start     <= 1'b0;
      r_recv_snap <= '0;
      r_err_snap  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sr        <= w_sr_nxt;
      r_fill      <= w_fill_nxt;
      r_match     <= w_match_nxt;
      r_win_bits  <= w_win_bits_nxt;
      r_win_errs  <= w_win_errs_nxt;
      r_recv_acc  <= w_recv_acc_nxt;
      r_err_acc   <= w_err_acc_nxt;
      r_period    <= w_period_nxt;
      r_start     <= w_start_nxt;
      r_recv_snap <= w_recv_snap_nxt;
      r_err_snap  <= w_err_snap_nxt;
    end
  end

  assign START    = r_start;
  assign RECV_CNT = r_recv_snap;
  assign ERR_CNT  = r_err_snap;
  assign LOCKED   = (r_state == StLock);

endmodule

// File: tb/tb_ber_prbs_checker.sv
// Bench for ber_prbs_checker: PRBS7 source with error injection, checked every cycle against a
// bit-level reference model plus directed checks on lock latency, snapshots and saturation.
module tb_ber_prbs_checker;

  localparam int unsigned PERIOD = 1000;
  localparam int unsigned SYNC   = 16;
  localparam int unsigned WIN    = 64;
  localparam int unsigned THRESH = 8;
  localparam longint unsigned RMAX = 64'h03FF_FFFF_FFFF_FFFF;
  localparam longint unsigned EMAX = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst, din, din_valid, clear;
  logic        start, locked;
  logic [57:0] recv_cnt;
  logic [63:0] err_cnt;

  always #5 clk = ~clk;

  ber_prbs_checker #(
    .REPORT_PERIOD(PERIOD),
    .SYNC_LEN     (SYNC),
    .LOL_WIN      (WIN),
    .LOL_THRESH   (THRESH)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .DIN      (din),
    .DIN_VALID(din_valid),
    .CLEAR    (clear),
    .START    (start),
    .RECV_CNT (recv_cnt),
    .ERR_CNT  (err_cnt),
    .LOCKED   (locked)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int g;
  int n_inj = 0;
  bit prev_locked = 1'b0;

  int              rise_cyc[$];
  int              fall_cyc[$];
  int              start_cyc[$];
  int              start_inj[$];
  longint unsigned start_recv[$];
  longint unsigned start_err[$];

  // Reference model: phase 0 = hunting, 1 = verifying, 2 = locked
  int              m_phase, m_cnt, m_win_bits, m_win_errs, m_period;
  bit              m_q[$];
  longint unsigned m_recv, m_err, m_recv_out, m_err_out;
  bit              m_start;

  task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit v, input bit d, input bit c, input bit r);
    bit p;
    if (r) begin
      m_phase = 0; m_cnt = 0; m_q.delete(); m_win_bits = 0; m_win_errs = 0;
      m_recv = 0; m_err = 0; m_period = 0; m_start = 0; m_recv_out = 0; m_err_out = 0;
      return;
    end
    if (v) begin
      p = (m_q.size() >= 2) ? (m_q[0] ^ m_q[1]) : 1'b0;
      if (m_phase == 0) begin
        m_q.push_back(d);
        m_cnt++;
        if (m_cnt == 7) begin m_phase = 1; m_cnt = 0; end
      end else if (m_phase == 1) begin
        if (d == p) begin
          m_q.push_back(d);
          m_cnt++;
          if (m_cnt == SYNC) begin m_phase = 2; m_win_bits = 0; m_win_errs = 0; end
        end else begin
          m_phase = 0; m_cnt = 0;
        end
      end else begin
        m_q.push_back(p);
        if (m_recv != RMAX) m_recv++;
        if (d != p) begin
          if (m_err != EMAX) m_err++;
          m_win_errs++;
        end
        m_win_bits++;
        if (m_win_bits == WIN) begin
          if (m_win_errs >= THRESH) begin m_phase = 0; m_cnt = 0; end
          m_win_bits = 0; m_win_errs = 0;
        end
      end
      while (m_q.size() > 7) void'(m_q.pop_front());
    end
    if (c) begin
      m_recv = 0; m_err = 0; m_period = 0; m_start = 0;
    end else begin
      m_start = (m_period == PERIOD - 1);
      if (m_start) begin m_recv_out = m_recv; m_err_out = m_err; end
      m_period = m_start ? 0 : m_period + 1;
    end
  endtask

  task automatic step(input bit v, input bit d, input bit c, input bit r);
    @(negedge clk);
    din_valid = v; din = d; clear = c; rst = r;
    @(posedge clk);
    model_step(v, d, c, r);
    cyc = r ? 0 : cyc + 1;
    #1;
    chk("START", 64'(start), 64'(m_start));
    chk("LOCKED", 64'(locked), 64'(m_phase == 2));
    chk("RECV_CNT", 64'(recv_cnt), m_recv_out);
    chk("ERR_CNT", err_cnt, m_err_out);
    if (locked && !prev_locked) rise_cyc.push_back(cyc);
    if (!locked && prev_locked) fall_cyc.push_back(cyc);
    prev_locked = locked;
    if (start) begin
      start_cyc.push_back(cyc);
      start_recv.push_back(64'(recv_cnt));
      start_err.push_back(err_cnt);
      start_inj.push_back(n_inj);
    end
  endtask

  // One PRBS7 source bit (optionally inverted) on valid cycles, junk otherwise
  task automatic send(input bit v, input bit inj, input bit c, input bit r);
    int nb;
    bit d;
    if (v) begin
      nb = ((g >> 6) ^ (g >> 5)) & 1;
      g  = ((g << 1) | nb) & 127;
      d  = nb[0] ^ inj;
      if (inj) n_inj++;
    end else begin
      d = 1'($urandom_range(0, 1));
    end
    step(v, d, c, r);
  endtask

  task automatic clear_logs();
    rise_cyc.delete(); fall_cyc.delete(); start_cyc.delete();
    start_recv.delete(); start_err.delete(); start_inj.delete();
  endtask

  int clear_at;

  initial begin
    rst = 1'b1; din = 1'b0; din_valid = 1'b0; clear = 1'b0;
    g = int'($urandom_range(1, 127));
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("reset_locked", 64'(locked), 64'd0);
    chk("reset_recv", 64'(recv_cnt), 64'd0);

    // Clean stream: lock after 23 bits, first snapshot 977, then +1000 each
    for (int i = 0; i < 2100; i++) send(1, 0, 0, 0);
    if (rise_cyc.size() > 0) chk("lock_cycle", 64'(rise_cyc[0]), 64'd23);
    else chk("lock_seen", 64'd0, 64'd1);
    if (start_recv.size() >= 2) begin
      chk("first_start_cycle", 64'(start_cyc[0]), 64'(PERIOD));
      chk("first_start_recv", start_recv[0], 64'd977);
      chk("first_start_err", start_err[0], 64'd0);
      chk("second_start_delta", start_recv[1] - start_recv[0], 64'd1000);
    end else chk("clean_starts_seen", 64'(start_recv.size()), 64'd2);

    // Sparse errors: one per 128 bits, lock held
    clear_logs();
    for (int i = 0; i < 2000; i++) send(1, (i % 128) == 5, 0, 0);
    chk("sparse_no_fall", 64'(fall_cyc.size()), 64'd0);
    if (start_err.size() >= 2)
      chk("sparse_err_delta", start_err[1] - start_err[0], 64'(start_inj[1] - start_inj[0]));
    else chk("sparse_starts_seen", 64'(start_err.size()), 64'd2);

    // Loss of lock: 8 errors at the head of one window
    for (int i = 0; i < 70 && m_win_bits != 0; i++) send(1, 0, 0, 0);
    clear_logs();
    for (int i = 0; i < 8; i++) send(1, 1, 0, 0);
    for (int i = 0; i < 200; i++) send(1, 0, 0, 0);
    if (fall_cyc.size() > 0 && rise_cyc.size() > 0)
      chk("relock_latency", 64'(rise_cyc[0] - fall_cyc[0]), 64'd23);
    else chk("lol_seen", 64'(fall_cyc.size() + rise_cyc.size()), 64'd2);

    // CLEAR on a snapshot cycle
    for (int i = 0; i < 1100 && m_period != PERIOD - 1; i++) send(1, 0, 0, 0);
    send(1, 0, 1, 0);
    chk("clear_no_start", 64'(start), 64'd0);
    clear_at = cyc;
    clear_logs();
    for (int i = 0; i < 1050; i++) send(1, 0, 0, 0);
    if (start_cyc.size() > 0) begin
      chk("clear_next_start", 64'(start_cyc[0] - clear_at), 64'(PERIOD));
      chk("clear_recv", start_recv[0], 64'd1000);
      chk("clear_err", start_err[0], 64'd0);
    end else chk("clear_start_seen", 64'd0, 64'd1);

    // DIN_VALID at 50% duty
    clear_logs();
    for (int i = 0; i < 2200; i++) send(i % 2 == 0, 0, 0, 0);
    if (start_recv.size() >= 2) begin
      chk("throttle_recv_delta", start_recv[1] - start_recv[0], 64'd500);
      chk("throttle_spacing", 64'(start_cyc[1] - start_cyc[0]), 64'(PERIOD));
    end else chk("throttle_starts_seen", 64'(start_recv.size()), 64'd2);

    // Saturation: preload both accumulators just below all-ones
    for (int i = 0; i < 1100 && m_period != 100; i++) send(1, 0, 0, 0);
    force dut.r_recv_acc = 58'h3FF_FFFF_FFFF_FFEB;
    force dut.r_err_acc  = 64'hFFFF_FFFF_FFFF_FFFD;
    m_recv = RMAX - 20;
    m_err  = EMAX - 2;
    send(0, 0, 0, 0);
    release dut.r_recv_acc;
    release dut.r_err_acc;
    clear_logs();
    for (int i = 0; i < 1000; i++) send(1, (i % 30) == 7 && i < 150, 0, 0);
    if (start_recv.size() > 0) begin
      chk("sat_recv", start_recv[0], RMAX);
      chk("sat_err", start_err[0], EMAX);
    end else chk("sat_start_seen", 64'd0, 64'd1);

    // Reset mid-stream
    send(1, 0, 0, 1);
    chk("rst_start", 64'(start), 64'd0);
    chk("rst_recv", 64'(recv_cnt), 64'd0);
    chk("rst_err", err_cnt, 64'd0);
    chk("rst_locked", 64'(locked), 64'd0);
    clear_logs();
    for (int i = 0; i < 40; i++) send(1, 0, 0, 0);
    if (rise_cyc.size() > 0) chk("rst_relock", 64'(rise_cyc[0]), 64'd23);
    else chk("rst_relock_seen", 64'd0, 64'd1);

    // Random traffic: throttled valid, sparse errors, occasional CLEAR
    for (int i = 0; i < 3000; i++)
      send($urandom_range(0, 3) != 0, $urandom_range(0, 99) < 3, $urandom_range(0, 999) == 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
